// File: rtl/elevator_controller.sv
// Three-floor elevator controller: latches active-low floor calls, steps the car between floors
// on step_clk pulses and times the door. Define ELEVATOR_BTN_SYNC_EN to add two-flop button synchronizers.
module elevator_controller #(
  parameter int TRAVEL_STEPS = 2,
  parameter int DOOR_STEPS   = 3
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       step_clk,
  output logic       moving,
  output logic [1:0] floor,
  output logic       door_open,
  output logic [2:0] pending,
  output logic       dir_up
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  localparam logic [3:0] TRAVEL_LAST = 4'(TRAVEL_STEPS - 1);
  localparam logic [3:0] DOOR_LAST   = 4'(DOOR_STEPS - 1);

  state_t     state, state_next;
  logic [1:0] floor_next;
  logic [2:0] pending_next;
  logic       dir_up_next;
  logic [3:0] cnt, cnt_next;

  logic [2:0] btn_in, btn_q, btn_prev, press;
  logic       step_q, step_prev, step;

  logic [2:0] here, pend_move;
  logic [1:0] arrive_floor;
  logic       up_calls, down_calls;

`ifdef ELEVATOR_BTN_SYNC_EN
  logic [2:0] btn_meta, btn_sync;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 3'b111;
      btn_sync <= 3'b111;
    end else begin
      btn_meta <= {button3, button2, button1};
      btn_sync <= btn_meta;
    end
  end

  assign btn_in = btn_sync;
`else
  assign btn_in = {button3, button2, button1};
`endif

  // Buttons idle high, so their edge registers reset to 1 and a press is a registered falling edge.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      btn_q     <= 3'b111;
      btn_prev  <= 3'b111;
      step_q    <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      btn_q     <= btn_in;
      btn_prev  <= btn_q;
      step_q    <= step_clk;
      step_prev <= step_q;
    end
  end

  assign press = btn_prev & ~btn_q;
  assign step  = step_q & ~step_prev;

  function automatic logic [2:0] hot(input logic [1:0] f);
    return 3'b001 << f;
  endfunction

  function automatic logic calls_above(input logic [2:0] p, input logic [1:0] f);
    case (f)
      2'd0:    return p[1] | p[2];
      2'd1:    return p[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic calls_below(input logic [2:0] p, input logic [1:0] f);
    case (f)
      2'd2:    return p[1] | p[0];
      2'd1:    return p[0];
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_next   = state;
    floor_next   = floor;
    pending_next = pending;
    dir_up_next  = dir_up;
    cnt_next     = cnt;
    here         = hot(floor);
    pend_move    = pending | press;
    arrive_floor = floor;
    up_calls     = calls_above(pending, floor);
    down_calls   = calls_below(pending, floor);

    case (state)
      IDLE: begin
        pending_next = pending | (press & ~here);
        if ((press & here) != 3'b000) begin
          state_next = DOOR;
          cnt_next   = '0;
        end else if (up_calls || down_calls) begin
          cnt_next = '0;
          // Keep the previous heading while it still has work, otherwise turn around.
          if (up_calls && (dir_up || !down_calls)) begin
            state_next  = MOVE_UP;
            dir_up_next = 1'b1;
          end else begin
            state_next  = MOVE_DOWN;
            dir_up_next = 1'b0;
          end
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        // A call for the floor being left is a real call; a call for the arrival floor is absorbed.
        pending_next = pend_move;
        if (step) begin
          if (cnt == TRAVEL_LAST) begin
            if (state == MOVE_UP)
              arrive_floor = (floor == 2'd2) ? 2'd2 : floor + 2'd1;
            else
              arrive_floor = (floor == 2'd0) ? 2'd0 : floor - 2'd1;
            floor_next = arrive_floor;
            cnt_next   = '0;
            if ((pend_move & hot(arrive_floor)) != 3'b000) begin
              pending_next = pend_move & ~hot(arrive_floor);
              state_next   = DOOR;
            end else if (state == MOVE_UP ? !calls_above(pend_move, arrive_floor)
                                          : !calls_below(pend_move, arrive_floor)) begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end
      end

      DOOR: begin
        pending_next = pending | (press & ~here);
        if ((press & here) != 3'b000) begin
          cnt_next = '0;
        end else if (step) begin
          if (cnt == DOOR_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      floor   <= 2'd0;
      pending <= 3'b000;
      dir_up  <= 1'b1;
      cnt     <= '0;
    end else begin
      state   <= state_next;
      floor   <= floor_next;
      pending <= pending_next;
      dir_up  <= dir_up_next;
      cnt     <= cnt_next;
    end
  end

  assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
  assign door_open = (state == DOOR);

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: directed scenarios with literal expectations, then random
// button/step traffic compared every cycle against a call-list model of the car.
module tb_elevator_controller;

  localparam int TRAVEL_STEPS = 2;
  localparam int DOOR_STEPS   = 3;
`ifdef ELEVATOR_BTN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       button1 = 1'b1;
  logic       button2 = 1'b1;
  logic       button3 = 1'b1;
  logic       step_clk = 1'b0;
  logic       moving;
  logic [1:0] floor;
  logic       door_open;
  logic [2:0] pending;
  logic       dir_up;

  int tests_run = 0;
  int tests_failed = 0;
  bit check_en = 1'b0;

  elevator_controller #(.TRAVEL_STEPS(TRAVEL_STEPS), .DOOR_STEPS(DOOR_STEPS)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .button1(button1), .button2(button2), .button3(button3),
    .step_clk(step_clk), .moving(moving), .floor(floor), .door_open(door_open),
    .pending(pending), .dir_up(dir_up)
  );

  always #5 clk_50 = ~clk_50;

  // Model: the car is a floor number, a list of calls, a heading (+1/-1/0) and a door countdown.
  int       m_floor;
  bit       m_call[3];
  int       m_travel;
  int       m_door_left;
  int       m_heading;
  bit       m_last_up;
  bit [2:0] raw_q, raw_prev, sync1, sync2;
  bit       stp_q, stp_prev;

  function automatic void check_output(string name, int actual, int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endfunction

  function automatic bit calls_toward(int f, int h);
    for (int i = f + h; i >= 0 && i < 3; i += h)
      if (m_call[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0;
    for (int i = 0; i < 3; i++) m_call[i] = 1'b0;
    m_travel = 0;
    m_door_left = 0;
    m_heading = 0;
    m_last_up = 1'b1;
    raw_q = 3'b111; raw_prev = 3'b111; sync1 = 3'b111; sync2 = 3'b111;
    stp_q = 1'b0; stp_prev = 1'b0;
  endtask

  task automatic model_tick();
    bit [2:0] press;
    bit [2:0] raw;
    bit       step;
    bit       up, dn;
    raw   = {button3, button2, button1};
    press = raw_prev & ~raw_q;
    step  = stp_q & ~stp_prev;
    if (m_heading != 0) begin
      for (int i = 0; i < 3; i++) if (press[i]) m_call[i] = 1'b1;
      if (step) begin
        m_travel++;
        if (m_travel == TRAVEL_STEPS) begin
          m_travel = 0;
          m_floor = m_floor + m_heading;
          if (m_floor < 0) m_floor = 0;
          if (m_floor > 2) m_floor = 2;
          if (m_call[m_floor]) begin
            m_call[m_floor] = 1'b0;
            m_heading = 0;
            m_door_left = DOOR_STEPS;
          end else if (!calls_toward(m_floor, m_heading)) begin
            m_heading = 0;
          end
        end
      end
    end else if (m_door_left > 0) begin
      for (int i = 0; i < 3; i++) if (press[i] && i != m_floor) m_call[i] = 1'b1;
      if (press[m_floor]) m_door_left = DOOR_STEPS;
      else if (step) m_door_left--;
    end else begin
      up = calls_toward(m_floor, 1);
      dn = calls_toward(m_floor, -1);
      if (press[m_floor]) begin
        m_door_left = DOOR_STEPS;
      end else if (up || dn) begin
        m_heading = (up && (m_last_up || !dn)) ? 1 : -1;
        m_last_up = (m_heading > 0);
        m_travel = 0;
      end
      for (int i = 0; i < 3; i++) if (press[i] && i != m_floor) m_call[i] = 1'b1;
    end
`ifdef ELEVATOR_BTN_SYNC_EN
    raw_prev = raw_q; raw_q = sync2; sync2 = sync1; sync1 = raw;
`else
    raw_prev = raw_q; raw_q = raw;
`endif
    stp_prev = stp_q; stp_q = step_clk;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_50 or negedge rst_n);
      if (!rst_n) model_reset();
      else model_tick();
    end
  end

  always @(negedge clk_50) begin
    if (check_en) begin
      check_output("model floor", floor, m_floor);
      check_output("model pending", pending, {m_call[2], m_call[1], m_call[0]});
      check_output("model moving", moving, (m_heading != 0));
      check_output("model door_open", door_open, (m_door_left > 0));
      check_output("model dir_up", dir_up, m_last_up);
    end
  end

  task automatic do_step();
    step_clk = 1'b1;
    repeat (2) @(negedge clk_50);
    step_clk = 1'b0;
    repeat (2) @(negedge clk_50);
  endtask

  task automatic press_btn(int f);
    if (f == 0) button1 = 1'b0; else if (f == 1) button2 = 1'b0; else button3 = 1'b0;
    @(negedge clk_50);
    button1 = 1'b1; button2 = 1'b1; button3 = 1'b1;
    repeat (2 + SYNC_LAT) @(negedge clk_50);
  endtask

  task automatic apply_stimulus();
    bit [2:0] b;
    b = {button3, button2, button1};
    if ($urandom_range(0, 2) == 0) step_clk = ~step_clk;
    for (int i = 0; i < 3; i++) begin
      if (!b[i]) b[i] = ($urandom_range(0, 1) == 0);
      else if ($urandom_range(0, 39) == 0) b[i] = 1'b0;
    end
    {button3, button2, button1} = b;
    if ($urandom_range(0, 1999) == 0) begin
      #2 rst_n = 1'b0;
      @(negedge clk_50);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk_50);
    check_output("reset floor", floor, 0);
    check_output("reset pending", pending, 0);
    check_output("reset moving", moving, 0);
    check_output("reset door_open", door_open, 0);
    check_output("reset dir_up", dir_up, 1);
    check_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk_50);

    // Call floor 1 from floor 0, ride up, and let the door time out.
    button2 = 1'b0;
    repeat (2) @(negedge clk_50);
    button2 = 1'b1;
    repeat (SYNC_LAT) @(negedge clk_50);
    check_output("call latched", pending, 3'b010);
    check_output("idle before move", moving, 0);
    @(negedge clk_50);
    check_output("departure moving", moving, 1);
    check_output("departure dir_up", dir_up, 1);
    repeat (2) do_step();
    check_output("arrive floor1", floor, 1);
    check_output("arrive door", door_open, 1);
    check_output("arrive pending", pending, 0);
    repeat (3) do_step();
    check_output("door timeout", door_open, 0);

    // Same-floor press opens the door; a second press restarts the count.
    press_btn(1);
    check_output("same-floor door", door_open, 1);
    check_output("same-floor pending", pending, 0);
    repeat (2) do_step();
    check_output("door after 2", door_open, 1);
    press_btn(1);
    repeat (2) do_step();
    check_output("door restarted", door_open, 1);
    do_step();
    check_output("door restart timeout", door_open, 0);

    // Press the destination in the very cycle the car arrives.
    press_btn(2);
    check_output("up to 2 moving", moving, 1);
    check_output("up to 2 pending", pending, 3'b100);
    do_step();
    step_clk = 1'b1;
    button3 = 1'b0;
    @(negedge clk_50);
    button3 = 1'b1;
    @(negedge clk_50);
    step_clk = 1'b0;
    repeat (2) @(negedge clk_50);
    check_output("arrive floor2", floor, 2);
    check_output("arrival press absorbed", pending, 0);
    check_output("arrive floor2 door", door_open, 1);
    repeat (3) do_step();
    check_output("single door cycle", door_open, 0);

    // Ride down past floor 1 to floor 0.
    press_btn(0);
    check_output("down moving", moving, 1);
    check_output("down dir_up", dir_up, 0);
    repeat (2) do_step();
    check_output("passing floor1", floor, 1);
    check_output("passing still moving", moving, 1);
    repeat (2) do_step();
    check_output("arrive floor0", floor, 0);
    check_output("arrive floor0 door", door_open, 1);
    repeat (3) do_step();

    // Reset while travelling up at floor 1.
    press_btn(2);
    repeat (2) do_step();
    check_output("mid-move floor", floor, 1);
    check_output("mid-move pending", pending, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort floor", floor, 0);
    check_output("abort moving", moving, 0);
    check_output("abort pending", pending, 0);
    @(negedge clk_50);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk_50);
      apply_stimulus();
    end
    @(negedge clk_50);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
